pulse_burst_gen: RTL and testbench
==================================

# pulse_burst_gen

Transmit-side companion to the pin edge counter. It drives a single output pin with a burst of N rectangular pulses. High and low durations are programmable in clock cycles, so the receiving counter on the far end of the wire can be exercised and checked against a known pulse count. The block sits between control logic (start/count/period registers) and an output pad, and reports progress and completion back to the control logic.

## Interface
- CNT_W, 16, width of pulse count and sent-pulse counter
- PER_W, 16, width of high/low period fields (cycles)

- CLK_IN  in  1  system clock; all logic on rising edge
- RST_N_IN  in  1  reset, synchronous, active-low
- start_i  in  1  request a burst; sampled only in IDLE
- abort_i  in  1  terminate an active burst
- pulse_count_i  in  CNT_W  number of pulses N; latched on accepted start
- high_cycles_i  in  PER_W  high time H in cycles; 0 treated as 1; latched on start
- low_cycles_i  in  PER_W  low time L in cycles; 0 treated as 1; latched on start
- pulse_o  out  1  registered pin drive
- busy_o  out  1  burst in progress
- done_o  out  1  one-cycle pulse on normal burst completion
- pulses_sent_o  out  CNT_W  completed pulses in current/last burst

## Operation
- Reset (RST_N_IN=0 at a clock edge) forces the following, regardless of state, including mid-burst:
  - state IDLE
  - pulse_o=0, busy_o=0, done_o=0, pulses_sent_o=0
  - internal timer and latched config cleared
- States are IDLE, HIGH and LOW.
- IDLE:
  - start_i=1 with pulse_count_i≠0 → latch N, H'=max(H,1), L'=max(L,1); clear pulses_sent_o; timer=H'; enter HIGH.
  - start_i=1 with pulse_count_i=0 → done_o pulses next cycle; stay IDLE; pulses_sent_o cleared; pulse_o stays 0.
  - abort_i in IDLE has no effect.
- HIGH:
  - pulse_o=1, busy_o=1; timer decrements each cycle.
  - On the last high cycle, pulses_sent_o increments.
  - If the new value equals N → enter IDLE with done_o=1 for one cycle. Otherwise → LOW with timer=L'.
- LOW:
  - pulse_o=0, busy_o=1; on the last low cycle, enter HIGH with timer=H'.
- start_i while busy_o=1 is ignored. Latched config is unaffected by input changes during a burst.
- abort_i=1 in HIGH or LOW:
  - next cycle: IDLE, pulse_o=0, busy_o=0, done_o stays 0.
  - pulses_sent_o keeps completed pulses; a truncated high phase is not counted.
  - abort has priority over timer expiry in the same cycle.
  - abort and start in the same cycle while busy → abort wins, start ignored.
- Arithmetic:
  - timers are PER_W-bit down-counters.
  - pulses_sent_o is CNT_W-bit and never exceeds N, so no wrap occurs.
  - N = 2^CNT_W−1 is legal.
- Period = H'+L' cycles. Duty = H'/(H'+L').

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- Start accepted at edge t: pulse_o=1 during cycles t+1 … t+H'.
- Pulse k (k=1..N) rises at t+1+(k−1)(H'+L') and falls at t+1+(k−1)(H'+L')+H'.
- pulses_sent_o increments in the same cycle pulse_o falls.
- Completion, in the cycle the N-th pulse falls (t+1+N·H'+(N−1)·L'): done_o=1, busy_o=0, pulse_o=0.
- A new start is accepted in that same completion cycle; the next burst's first pulse follows one cycle later, giving a 1-cycle minimum gap.
- Maximum toggle rate (H=L=1) is CLK_IN/2. This stays within the counter's 2-flop synchronizer + edge-detect capability when both sides share a clock.

## Test plan
- Reset mid-burst: start N=5, H=3, L=2, assert RST_N_IN=0 during second HIGH → next edge pulse_o=0, busy_o=0, pulses_sent_o=0; done_o never asserted.
- Nominal burst: start N=4, H=3, L=2 → pulse_o high 3 / low 2 cycles, four pulses; done_o single cycle at t+1+4·3+3·2 = t+19; pulses_sent_o=4.
- Zero fields: start N=3, H=0, L=0 → behaves as H=L=1, toggling every cycle, done at t+6. Separately, start N=0 → done_o at t+1, pulse_o never rises.
- Abort: start N=10, H=4, L=4; abort_i during the 3rd high phase → pulse_o=0 next cycle, busy_o=0, pulses_sent_o=2, no done_o. Repeat with abort on the exact timer-expiry cycle → abort wins.
- Busy start ignored and back-to-back: pulse start_i with different config while busy → no effect on the waveform. Issue start N=2 in the completion cycle → second burst begins next cycle with cleared pulses_sent_o.
- Loopback: pulse_o wired to the edge counter input, N=200, H=L=1 → counter low byte increases by exactly 200 after the synchronizer latency.

Source files
------------

// File: rtl/pulse_burst_gen_if.sv
// rtl/pulse_burst_gen_if.sv - control/status bundle between burst control logic and pulse_burst_gen
interface pulse_burst_gen_if #(
  parameter int CNT_W = 16,
  parameter int PER_W = 16
) ();
  logic             start_i;
  logic             abort_i;
  logic [CNT_W-1:0] pulse_count_i;
  logic [PER_W-1:0] high_cycles_i;
  logic [PER_W-1:0] low_cycles_i;
  logic             pulse_o;
  logic             busy_o;
  logic             done_o;
  logic [CNT_W-1:0] pulses_sent_o;

  modport master (
    output start_i, abort_i, pulse_count_i, high_cycles_i, low_cycles_i,
    input  pulse_o, busy_o, done_o, pulses_sent_o
  );

  modport slave (
    input  start_i, abort_i, pulse_count_i, high_cycles_i, low_cycles_i,
    output pulse_o, busy_o, done_o, pulses_sent_o
  );
endinterface

// File: rtl/pulse_burst_gen.sv
// rtl/pulse_burst_gen.sv - programmable burst of N rectangular pulses on a registered output pin
module pulse_burst_gen #(
  parameter int CNT_W = 16,
  parameter int PER_W = 16
) (
  input  logic              CLK_IN,
  input  logic              RST_N_IN,
  pulse_burst_gen_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PER_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PER_W-1:0] high_q, high_d;
  logic [PER_W-1:0] low_q, low_d;
  logic [CNT_W-1:0] sent_q, sent_d;
  logic             pulse_q, pulse_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [PER_W-1:0] high_eff;
  logic [PER_W-1:0] low_eff;
  logic [CNT_W-1:0] sent_inc;
  logic             timer_last;

  // Zero-length phases would stall the down-counter, so they run as one cycle.
  assign high_eff   = (bus.high_cycles_i == '0) ? PER_W'(1) : bus.high_cycles_i;
  assign low_eff    = (bus.low_cycles_i == '0) ? PER_W'(1) : bus.low_cycles_i;
  assign sent_inc   = sent_q + CNT_W'(1);
  assign timer_last = (timer_q == PER_W'(1));

  always_ff @(posedge CLK_IN) begin
    if (!RST_N_IN) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      count_q <= '0;
      high_q  <= '0;
      low_q   <= '0;
      sent_q  <= '0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      count_q <= count_d;
      high_q  <= high_d;
      low_q   <= low_d;
      sent_q  <= sent_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    count_d = count_q;
    high_d  = high_q;
    low_d   = low_q;
    sent_d  = sent_q;
    pulse_d = pulse_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        pulse_d = 1'b0;
        busy_d  = 1'b0;
        if (bus.start_i) begin
          sent_d = '0;
          if (bus.pulse_count_i == '0) begin
            done_d = 1'b1;
          end else begin
            count_d = bus.pulse_count_i;
            high_d  = high_eff;
            low_d   = low_eff;
            timer_d = high_eff;
            state_d = S_HIGH;
            pulse_d = 1'b1;
            busy_d  = 1'b1;
          end
        end
      end

      S_HIGH: begin
        // Abort beats expiry, so a truncated high phase is never counted.
        if (bus.abort_i) begin
          state_d = S_IDLE;
          pulse_d = 1'b0;
          busy_d  = 1'b0;
        end else if (timer_last) begin
          sent_d  = sent_inc;
          pulse_d = 1'b0;
          if (sent_inc == count_q) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = S_LOW;
            timer_d = low_q;
          end
        end else begin
          timer_d = timer_q - PER_W'(1);
        end
      end

      S_LOW: begin
        if (bus.abort_i) begin
          state_d = S_IDLE;
          pulse_d = 1'b0;
          busy_d  = 1'b0;
        end else if (timer_last) begin
          state_d = S_HIGH;
          timer_d = high_q;
          pulse_d = 1'b1;
        end else begin
          timer_d = timer_q - PER_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        pulse_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bus.pulse_o       = pulse_q;
  assign bus.busy_o        = busy_q;
  assign bus.done_o        = done_q;
  assign bus.pulses_sent_o = sent_q;

endmodule

// File: tb/tb_pulse_burst_gen.sv
// tb/tb_pulse_burst_gen.sv - directed self-checking bench for pulse_burst_gen
module tb_pulse_burst_gen;
  localparam int CNT_W = 16;
  localparam int PER_W = 16;

  logic CLK_IN = 1'b0;
  logic RST_N_IN = 1'b0;
  int   checks = 0;
  int   failures = 0;

  pulse_burst_gen_if #(.CNT_W(CNT_W), .PER_W(PER_W)) bus ();

  pulse_burst_gen #(.CNT_W(CNT_W), .PER_W(PER_W)) dut (
    .CLK_IN   (CLK_IN),
    .RST_N_IN (RST_N_IN),
    .bus      (bus.slave)
  );

  always #5 CLK_IN = ~CLK_IN;

  // Far-end edge counter: 2-flop synchronizer plus rising-edge detect.
  logic       lb_s1 = 1'b0, lb_s2 = 1'b0, lb_s3 = 1'b0;
  logic [7:0] lb_cnt = 8'd0;
  always @(posedge CLK_IN) begin
    lb_s1 <= bus.pulse_o;
    lb_s2 <= lb_s1;
    lb_s3 <= lb_s2;
    if (lb_s2 && !lb_s3) lb_cnt <= lb_cnt + 8'd1;
  end

  function automatic logic [18:0] obs();
    return {bus.pulse_o, bus.busy_o, bus.done_o, bus.pulses_sent_o};
  endfunction

  // Expected {pulse, busy, done, sent} in cycle c after the start edge (c >= 1), n >= 1.
  function automatic logic [18:0] exp_vec(input int c, input int n, input int h, input int l);
    int hh, ll, p, e, idx, s;
    logic pl, b, d;
    hh  = (h == 0) ? 1 : h;
    ll  = (l == 0) ? 1 : l;
    p   = hh + ll;
    e   = 1 + (n - 1) * p + hh;
    idx = c - 1;
    pl  = ((idx / p) < n) && ((idx % p) < hh);
    b   = (c < e);
    d   = (c == e);
    s   = (c < 1 + hh) ? 0 : ((c - 1 - hh) / p + 1);
    if (s > n) s = n;
    return {pl, b, d, 16'(s)};
  endfunction

  task automatic do_reset();
    RST_N_IN = 1'b0;
    repeat (2) @(posedge CLK_IN);
    #1 RST_N_IN = 1'b1;
  endtask

  task automatic start_burst(input int n, input int h, input int l);
    bus.pulse_count_i = 16'(n);
    bus.high_cycles_i = 16'(h);
    bus.low_cycles_i  = 16'(l);
    bus.start_i = 1'b1;
    @(posedge CLK_IN);
    #1 bus.start_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge CLK_IN);
    checks++;
    if (obs() !== 19'h0) begin
      failures++;
      $display("FAIL reset got=%h exp=%h", obs(), 19'h0);
    end
  endtask

  task automatic test_reset_mid_burst();
    start_burst(5, 3, 2);
    for (int c = 1; c <= 7; c++) begin
      @(negedge CLK_IN);
      checks++;
      if (obs() !== exp_vec(c, 5, 3, 2)) begin
        failures++;
        $display("FAIL reset_mid c=%0d got=%h exp=%h", c, obs(), exp_vec(c, 5, 3, 2));
      end
    end
    RST_N_IN = 1'b0;
    @(posedge CLK_IN);
    #1 RST_N_IN = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK_IN);
      checks++;
      if (obs() !== 19'h0) begin
        failures++;
        $display("FAIL reset_mid_after k=%0d got=%h exp=%h", c, obs(), 19'h0);
      end
    end
  endtask

  task automatic test_nominal();
    start_burst(4, 3, 2);
    for (int c = 1; c <= 21; c++) begin
      @(negedge CLK_IN);
      checks++;
      if (obs() !== exp_vec(c, 4, 3, 2)) begin
        failures++;
        $display("FAIL nominal c=%0d got=%h exp=%h", c, obs(), exp_vec(c, 4, 3, 2));
      end
    end
  endtask

  task automatic test_zero_fields();
    start_burst(3, 0, 0);
    for (int c = 1; c <= 8; c++) begin
      @(negedge CLK_IN);
      checks++;
      if (obs() !== exp_vec(c, 3, 1, 1)) begin
        failures++;
        $display("FAIL zero_hl c=%0d got=%h exp=%h", c, obs(), exp_vec(c, 3, 1, 1));
      end
    end
    start_burst(0, 5, 5);
    for (int c = 1; c <= 4; c++) begin
      @(negedge CLK_IN);
      checks++;
      if (obs() !== ((c == 1) ? 19'h10000 : 19'h0)) begin
        failures++;
        $display("FAIL zero_n c=%0d got=%h exp=%h", c, obs(), (c == 1) ? 19'h10000 : 19'h0);
      end
    end
  endtask

  task automatic test_abort();
    // Mid third high phase (cycles 17..20).
    start_burst(10, 4, 4);
    for (int c = 1; c <= 18; c++) begin
      @(negedge CLK_IN);
      checks++;
      if (obs() !== exp_vec(c, 10, 4, 4)) begin
        failures++;
        $display("FAIL abort_mid c=%0d got=%h exp=%h", c, obs(), exp_vec(c, 10, 4, 4));
      end
    end
    bus.abort_i = 1'b1;
    @(posedge CLK_IN);
    #1 bus.abort_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK_IN);
      checks++;
      if (obs() !== 19'h00002) begin
        failures++;
        $display("FAIL abort_mid_after k=%0d got=%h exp=%h", c, obs(), 19'h00002);
      end
    end
    // Abort in IDLE leaves everything as it was.
    bus.abort_i = 1'b1;
    @(posedge CLK_IN);
    #1 bus.abort_i = 1'b0;
    @(negedge CLK_IN);
    checks++;
    if (obs() !== 19'h00002) begin
      failures++;
      $display("FAIL abort_idle got=%h exp=%h", obs(), 19'h00002);
    end
    // Abort on the last high cycle of the third pulse: that pulse is not counted.
    start_burst(10, 4, 4);
    for (int c = 1; c <= 20; c++) begin
      @(negedge CLK_IN);
      checks++;
      if (obs() !== exp_vec(c, 10, 4, 4)) begin
        failures++;
        $display("FAIL abort_exp c=%0d got=%h exp=%h", c, obs(), exp_vec(c, 10, 4, 4));
      end
    end
    bus.abort_i = 1'b1;
    @(posedge CLK_IN);
    #1 bus.abort_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK_IN);
      checks++;
      if (obs() !== 19'h00002) begin
        failures++;
        $display("FAIL abort_exp_after k=%0d got=%h exp=%h", c, obs(), 19'h00002);
      end
    end
    // Abort together with start while busy: abort wins, start dropped.
    start_burst(10, 4, 4);
    for (int c = 1; c <= 5; c++) begin
      @(negedge CLK_IN);
      checks++;
      if (obs() !== exp_vec(c, 10, 4, 4)) begin
        failures++;
        $display("FAIL abort_start c=%0d got=%h exp=%h", c, obs(), exp_vec(c, 10, 4, 4));
      end
    end
    bus.abort_i = 1'b1;
    start_burst(1, 2, 2);
    bus.abort_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK_IN);
      checks++;
      if (obs() !== 19'h00001) begin
        failures++;
        $display("FAIL abort_start_after k=%0d got=%h exp=%h", c, obs(), 19'h00001);
      end
    end
  endtask

  task automatic test_busy_start();
    start_burst(3, 2, 3);
    for (int c = 1; c <= 15; c++) begin
      @(negedge CLK_IN);
      checks++;
      if (obs() !== exp_vec(c, 3, 2, 3)) begin
        failures++;
        $display("FAIL busy_start c=%0d got=%h exp=%h", c, obs(), exp_vec(c, 3, 2, 3));
      end
      if (c == 4) start_burst(1, 7, 1);
    end
  endtask

  task automatic test_back_to_back();
    start_burst(1, 2, 1);
    for (int c = 1; c <= 3; c++) begin
      @(negedge CLK_IN);
      checks++;
      if (obs() !== exp_vec(c, 1, 2, 1)) begin
        failures++;
        $display("FAIL b2b_first c=%0d got=%h exp=%h", c, obs(), exp_vec(c, 1, 2, 1));
      end
    end
    start_burst(2, 1, 2);
    for (int c = 1; c <= 7; c++) begin
      @(negedge CLK_IN);
      checks++;
      if (obs() !== exp_vec(c, 2, 1, 2)) begin
        failures++;
        $display("FAIL b2b_second c=%0d got=%h exp=%h", c, obs(), exp_vec(c, 2, 1, 2));
      end
    end
  endtask

  task automatic test_loopback();
    logic [7:0] base;
    int         dones;
    base  = lb_cnt;
    dones = 0;
    start_burst(200, 1, 1);
    for (int c = 1; c <= 410; c++) begin
      @(negedge CLK_IN);
      if (bus.done_o) dones++;
    end
    checks++;
    if (8'(lb_cnt - base) !== 8'd200) begin
      failures++;
      $display("FAIL loopback_count got=%0d exp=%0d", 8'(lb_cnt - base), 200);
    end
    checks++;
    if (obs() !== {3'b000, 16'd200}) begin
      failures++;
      $display("FAIL loopback_final got=%h exp=%h", obs(), {3'b000, 16'd200});
    end
    checks++;
    if (dones !== 1) begin
      failures++;
      $display("FAIL loopback_done got=%0d exp=%0d", dones, 1);
    end
  endtask

  initial begin
    bus.start_i       = 1'b0;
    bus.abort_i       = 1'b0;
    bus.pulse_count_i = '0;
    bus.high_cycles_i = '0;
    bus.low_cycles_i  = '0;
    test_reset();
    test_reset_mid_burst();
    test_nominal();
    test_zero_fields();
    test_abort();
    test_busy_start();
    test_back_to_back();
    test_loopback();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
